decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 29 ++
 rtl/decode_stage_if.sv | 41 ++++
 rtl/decode_stage_fields.sv | 66 ++++++
 rtl/decode_stage.sv | 132 +++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode values and the decoded
// control-flag bundle.
package decode_stage_pkg;

  localparam int OPCODE_W = 6;

  localparam logic [OPCODE_W-1:0] OP_J    = 6'h02;
  localparam logic [OPCODE_W-1:0] OP_JAL  = 6'h03;
  localparam logic [OPCODE_W-1:0] OP_JR   = 6'h04;
  localparam logic [OPCODE_W-1:0] OP_JALR = 6'h05;
  localparam logic [OPCODE_W-1:0] OP_LW   = 6'h23;
  localparam logic [OPCODE_W-1:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic branch_taken;
    logic link;
    logic from_register;
    logic ram_enable_write;
    logic ram_enable_read;
  } dec_flags_t;

  localparam dec_flags_t FLAGS_NONE = '0;

  // Saturating increment used by the load-use stall counter.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Handshake and decoded-output bundle of the decode stage. The producer /
// consumer side (bench or neighbouring stages) uses master, the stage uses slave.
interface decode_stage_if #(
  parameter int R_ADDR_SIZE      = 5,
  parameter int OP_SIZE          = 6,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int DATA_SIZE        = 32
);
  logic                        in_valid;
  logic                        in_ready;
  logic [INSTRUCTION_SIZE-1:0] instruction;
  logic                        flush;
  logic                        out_valid;
  logic                        out_ready;
  logic [OP_SIZE-1:0]          operation;
  logic [DATA_SIZE-1:0]        inmediate;
  logic [R_ADDR_SIZE-1:0]      destination;
  logic [R_ADDR_SIZE-1:0]      read0;
  logic [R_ADDR_SIZE-1:0]      read1;
  logic [R_ADDR_SIZE-1:0]      read2;
  logic                        branch_taken;
  logic                        link;
  logic                        from_register;
  logic                        ram_enable_write;
  logic                        ram_enable_read;
  logic [15:0]                 stall_count;

  modport master (
    output in_valid, instruction, flush, out_ready,
    input  in_ready, out_valid, operation, inmediate, destination,
           read0, read1, read2, branch_taken, link, from_register,
           ram_enable_write, ram_enable_read, stall_count
  );

  modport slave (
    input  in_valid, instruction, flush, out_ready,
    output in_ready, out_valid, operation, inmediate, destination,
           read0, read1, read2, branch_taken, link, from_register,
           ram_enable_write, ram_enable_read, stall_count
  );
endinterface

// File: rtl/decode_stage_fields.sv
// Purely combinational instruction cracking: opcode, register fields,
// control flags and immediate extension.
module decode_fields
  import decode_stage_pkg::*;
#(
  parameter int R_ADDR_SIZE      = 5,
  parameter int OP_SIZE          = 6,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int INMEDIATE_SIZE   = 16,
  parameter int ZERO_PAD         = 11,
  parameter int DATA_SIZE        = 32,
  parameter int SIGN_EXTEND      = 1
) (
  input  logic [INSTRUCTION_SIZE-1:0] instruction_i,
  output logic [OP_SIZE-1:0]          operation_o,
  output logic [DATA_SIZE-1:0]        inmediate_o,
  output logic [R_ADDR_SIZE-1:0]      read0_o,
  output logic [R_ADDR_SIZE-1:0]      read1_o,
  output logic [R_ADDR_SIZE-1:0]      read2_o,
  output dec_flags_t                  flags_o
);

  logic [INMEDIATE_SIZE-1:0] imm_raw;

  assign operation_o = instruction_i[INSTRUCTION_SIZE-1 -: OP_SIZE];
  assign imm_raw     = instruction_i[INMEDIATE_SIZE-1:0];
  assign read0_o     = instruction_i[ZERO_PAD                 +: R_ADDR_SIZE];
  assign read1_o     = instruction_i[ZERO_PAD +   R_ADDR_SIZE +: R_ADDR_SIZE];
  assign read2_o     = instruction_i[ZERO_PAD + 2*R_ADDR_SIZE +: R_ADDR_SIZE];

  // Size cast of a signed operand replicates the sign bit.
  generate
    if (SIGN_EXTEND != 0) begin : g_sext
      assign inmediate_o = DATA_SIZE'($signed(imm_raw));
    end else begin : g_zext
      assign inmediate_o = DATA_SIZE'(imm_raw);
    end
  endgenerate

  // Opcode to control-flag decode; unknown opcodes carry no side effects.
  always_comb begin
    flags_o = FLAGS_NONE;
    case (operation_o)
      OP_SIZE'(OP_J): begin
        flags_o.branch_taken = 1'b1;
      end
      OP_SIZE'(OP_JR): begin
        flags_o.branch_taken  = 1'b1;
        flags_o.from_register = 1'b1;
      end
      OP_SIZE'(OP_JAL): begin
        flags_o.branch_taken = 1'b1;
        flags_o.link         = 1'b1;
      end
      OP_SIZE'(OP_JALR): begin
        flags_o.branch_taken  = 1'b1;
        flags_o.link          = 1'b1;
        flags_o.from_register = 1'b1;
      end
      OP_SIZE'(OP_SW): flags_o.ram_enable_write = 1'b1;
      OP_SIZE'(OP_LW): flags_o.ram_enable_read  = 1'b1;
      default:         flags_o = FLAGS_NONE;
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: one-entry output register with valid/ready
// handshake, load-use hazard bubble insertion, flush and stall counter.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int R_ADDR_SIZE      = 5,
  parameter int OP_SIZE          = 6,
  parameter int INSTRUCTION_SIZE = 32,
  parameter int INMEDIATE_SIZE   = 16,
  parameter int ZERO_PAD         = 11,
  parameter int DATA_SIZE        = 32,
  parameter int SIGN_EXTEND      = 1
) (
  input logic           clk,
  input logic           reset_n,
  decode_stage_if.slave bus
);

  logic [OP_SIZE-1:0]     dec_op;
  logic [DATA_SIZE-1:0]   dec_imm;
  logic [R_ADDR_SIZE-1:0] dec_r0, dec_r1, dec_r2;
  dec_flags_t             dec_flags;

  decode_fields #(
    .R_ADDR_SIZE      (R_ADDR_SIZE),
    .OP_SIZE          (OP_SIZE),
    .INSTRUCTION_SIZE (INSTRUCTION_SIZE),
    .INMEDIATE_SIZE   (INMEDIATE_SIZE),
    .ZERO_PAD         (ZERO_PAD),
    .DATA_SIZE        (DATA_SIZE),
    .SIGN_EXTEND      (SIGN_EXTEND)
  ) u_fields (
    .instruction_i (bus.instruction),
    .operation_o   (dec_op),
    .inmediate_o   (dec_imm),
    .read0_o       (dec_r0),
    .read1_o       (dec_r1),
    .read2_o       (dec_r2),
    .flags_o       (dec_flags)
  );

  logic                   valid_q, valid_d;
  dec_flags_t             flags_q, flags_d;
  logic [OP_SIZE-1:0]     op_q, op_d;
  logic [DATA_SIZE-1:0]   imm_q, imm_d;
  logic [R_ADDR_SIZE-1:0] r0_q, r0_d;
  logic [R_ADDR_SIZE-1:0] r1_q, r1_d;
  logic [R_ADDR_SIZE-1:0] r2_q, r2_d;
  logic [15:0]            stall_q, stall_d;

  logic hold;
  logic hazard;
  logic in_ready;

  // Held load whose destination the incoming instruction reads; r0 is never written.
  assign hazard = valid_q && flags_q.ram_enable_read && bus.in_valid &&
                  (r2_q != '0) && ((dec_r0 == r2_q) || (dec_r1 == r2_q));
  assign hold     = valid_q && !bus.out_ready;
  assign in_ready = !hold && !hazard && !bus.flush;

  // Next-state selection: flush beats hold, hold beats bubble, bubble beats accept.
  always_comb begin
    valid_d = valid_q;
    flags_d = flags_q;
    op_d    = op_q;
    imm_d   = imm_q;
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    stall_d = stall_q;
    if (bus.flush) begin
      valid_d = 1'b0;
      flags_d = FLAGS_NONE;
    end else if (hold) begin
      valid_d = valid_q;
    end else if (hazard) begin
      valid_d = 1'b0;
      flags_d = FLAGS_NONE;
      stall_d = sat_inc16(stall_q);
    end else if (bus.in_valid) begin
      valid_d = 1'b1;
      flags_d = dec_flags;
      op_d    = dec_op;
      imm_d   = dec_imm;
      r0_d    = dec_r0;
      r1_d    = dec_r1;
      r2_d    = dec_r2;
    end else begin
      valid_d = 1'b0;
      flags_d = FLAGS_NONE;
    end
  end

  // Output register and stall counter; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      flags_q <= FLAGS_NONE;
      op_q    <= '0;
      imm_q   <= '0;
      r0_q    <= '0;
      r1_q    <= '0;
      r2_q    <= '0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      flags_q <= flags_d;
      op_q    <= op_d;
      imm_q   <= imm_d;
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      stall_q <= stall_d;
    end
  end

  assign bus.in_ready         = in_ready;
  assign bus.out_valid        = valid_q;
  assign bus.operation        = op_q;
  assign bus.inmediate        = imm_q;
  assign bus.read0            = r0_q;
  assign bus.read1            = r1_q;
  assign bus.read2            = r2_q;
  assign bus.destination      = r2_q;
  assign bus.branch_taken     = flags_q.branch_taken;
  assign bus.link             = flags_q.link;
  assign bus.from_register    = flags_q.from_register;
  assign bus.ram_enable_write = flags_q.ram_enable_write;
  assign bus.ram_enable_read  = flags_q.ram_enable_read;
  assign bus.stall_count      = stall_q;

endmodule
